// File: rtl/cam_rgb_capture_pkg.sv
// Shared constants, FSM encoding and colour packing for the OV7670 capture path.
// The downstream pixel counter imports FRAME_PIX from here as well.
package cam_rgb_capture_pkg;

  localparam int QQVGA_H   = 160;
  localparam int QQVGA_V   = 120;
  localparam int FRAME_PIX = QQVGA_H * QQVGA_V;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_SOF = 2'd1,
    ST_BYTE_HI  = 2'd2,
    ST_BYTE_LO  = 2'd3
  } cap_state_e;

  // RGB565 arrives as {R4..R0,G5..G3} then {G2..G0,B4..B0}; keep the MSBs of each channel.
  function automatic logic [7:0] rgb565_to_332(input logic [7:0] hi, input logic [7:0] lo);
    return {hi[7:5], hi[2:0], lo[4:3]};
  endfunction

endpackage

// File: rtl/cam_rgb_capture_edge_det.sv
// Registers the previous value of a camera sync line and flags its edges.
// Edge outputs are combinational from the live input and the registered history.
module cam_rgb_capture_edge_det (
  input  logic pclk,
  input  logic in_reset,
  input  logic i_sig,
  output logic o_rise,
  output logic o_fall
);

  logic r_prev;

  always_ff @(posedge pclk) begin
    if (in_reset) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= i_sig;
    end
  end

  assign o_rise = i_sig & ~r_prev;
  assign o_fall = ~i_sig & r_prev;

endmodule

// File: rtl/cam_rgb_capture.sv
// OV7670 RGB565 byte stream to RGB332 frame-buffer writes with a linear address.
// px_wr is a one-cycle strobe with no back-pressure; mem_px_addr/mem_px_data are valid only while it is high.
module cam_rgb_capture
  import cam_rgb_capture_pkg::*;
#(
  parameter int H_PIX   = QQVGA_H,
  parameter int V_LINES = QQVGA_V,
  parameter int AW      = 15
) (
  input  logic          pclk,
  input  logic          in_reset,
  input  logic          inicio,
  input  logic          vsync,
  input  logic          href,
  input  logic [7:0]    px_data,
  output logic [AW-1:0] mem_px_addr,
  output logic [7:0]    mem_px_data,
  output logic          px_wr,
  output logic          add_cnt,
  output logic          frame_done,
  output cap_state_e    o_dbg_state
);

  localparam int CW = $clog2(H_PIX + 1);
  localparam int LW = $clog2(V_LINES + 1);
  localparam logic [CW-1:0] COL_END   = CW'(H_PIX);
  localparam logic [LW-1:0] LINE_END  = LW'(V_LINES);
  localparam logic [AW-1:0] LAST_ADDR = AW'(H_PIX * V_LINES - 1);

  logic w_vsync_rise, w_vsync_fall;
  logic w_href_fall, w_unused_href_rise;

  cam_rgb_capture_edge_det u_vsync_ed (
    .pclk     (pclk),
    .in_reset (in_reset),
    .i_sig    (vsync),
    .o_rise   (w_vsync_rise),
    .o_fall   (w_vsync_fall)
  );

  cam_rgb_capture_edge_det u_href_ed (
    .pclk     (pclk),
    .in_reset (in_reset),
    .i_sig    (href),
    .o_rise   (w_unused_href_rise),
    .o_fall   (w_href_fall)
  );

  cap_state_e    r_state;
  logic [AW-1:0] r_addr;
  logic [CW-1:0] r_col;
  logic [LW-1:0] r_line;
  logic          r_line_has_byte;
  logic [7:0]    r_hi;
  logic [7:0]    r_px_data;
  logic          r_px_wr;
  logic          r_add_cnt;
  logic          r_frame_done;
  logic          w_in_window;

  assign w_in_window = (r_col != COL_END) && (r_line != LINE_END);

  always_ff @(posedge pclk) begin
    if (in_reset) begin
      r_state         <= ST_IDLE;
      r_addr          <= '0;
      r_col           <= '0;
      r_line          <= '0;
      r_line_has_byte <= 1'b0;
      r_hi            <= '0;
      r_px_data       <= '0;
      r_px_wr         <= 1'b0;
      r_add_cnt       <= 1'b1;
      r_frame_done    <= 1'b0;
    end else begin
      r_px_wr      <= 1'b0;
      r_add_cnt    <= 1'b1;
      r_frame_done <= 1'b0;
      // The address stays on the written pixel for its strobe cycle and steps afterwards.
      if (r_px_wr && (r_addr != LAST_ADDR)) begin
        r_addr <= r_addr + 1'b1;
      end
      unique case (r_state)
        ST_IDLE: begin
          if (inicio) r_state <= ST_WAIT_SOF;
        end
        ST_WAIT_SOF: begin
          if (w_vsync_fall) begin
            r_addr          <= '0;
            r_col           <= '0;
            r_line          <= '0;
            r_line_has_byte <= 1'b0;
            r_state         <= ST_BYTE_HI;
          end
        end
        ST_BYTE_HI, ST_BYTE_LO: begin
          if (w_href_fall && r_line_has_byte) begin
            r_line_has_byte <= 1'b0;
            r_col           <= '0;
            if (r_line != LINE_END) r_line <= r_line + 1'b1;
          end
          // A vsync rise mid-frame is a short frame: abort after any line-end bookkeeping.
          if (w_vsync_rise) begin
            r_state <= ST_WAIT_SOF;
          end else if (r_state == ST_BYTE_HI) begin
            if (href) begin
              r_hi            <= px_data;
              r_line_has_byte <= 1'b1;
              r_state         <= ST_BYTE_LO;
            end
          end else begin
            r_state <= ST_BYTE_HI;
            if (href) begin
              r_line_has_byte <= 1'b1;
              if (r_col != COL_END) r_col <= r_col + 1'b1;
              if (w_in_window) begin
                r_px_data <= rgb565_to_332(r_hi, px_data);
                r_px_wr   <= 1'b1;
                r_add_cnt <= 1'b0;
                if (r_addr == LAST_ADDR) begin
                  r_frame_done <= 1'b1;
                  r_state      <= inicio ? ST_WAIT_SOF : ST_IDLE;
                end
              end
            end
          end
        end
      endcase
    end
  end

  assign mem_px_addr = r_addr;
  assign mem_px_data = r_px_data;
  assign px_wr       = r_px_wr;
  assign add_cnt     = r_add_cnt;
  assign frame_done  = r_frame_done;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_cam_rgb_capture.sv
// Directed bench for cam_rgb_capture: a line-level pixel model feeds an expected-write queue
// that a per-cycle compare process drains; literal expectations pin the model.
module tb_cam_rgb_capture;
  import cam_rgb_capture_pkg::*;

  localparam int H    = 160;
  localparam int V    = 120;
  localparam int NPIX = H * V;

  // clock / reset / stimulus signals
  logic        clk     = 1'b0;
  logic        rst     = 1'b1;
  logic        inicio  = 1'b0;
  logic        vsync   = 1'b0;
  logic        href    = 1'b0;
  logic [7:0]  px_data = 8'd0;
  logic [14:0] mem_px_addr;
  logic [7:0]  mem_px_data;
  logic        px_wr;
  logic        add_cnt;
  logic        frame_done;
  cap_state_e  dbg_state;

  always #5 clk = ~clk;

  cam_rgb_capture #(.H_PIX(H), .V_LINES(V), .AW(15)) dut (
    .pclk        (clk),
    .in_reset    (rst),
    .inicio      (inicio),
    .vsync       (vsync),
    .href        (href),
    .px_data     (px_data),
    .mem_px_addr (mem_px_addr),
    .mem_px_data (mem_px_data),
    .px_wr       (px_wr),
    .add_cnt     (add_cnt),
    .frame_done  (frame_done),
    .o_dbg_state (dbg_state)
  );

  // scoreboard state
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_wr = 0;
  int          n_acl = 0;
  int          n_fd = 0;
  logic        chk_en = 1'b0;
  logic [23:0] exp_q[$];
  logic [22:0] obs_q[$];
  logic [23:0] sb_e;
  logic [14:0] fd_addr = '1;

  // behavioural model state
  int          m_addr = 0;
  int          m_col = 0;
  int          m_line = 0;
  bit          m_idle = 1'b1;
  bit          m_cap = 1'b0;
  logic [7:0]  line_buf [0:399];

  int          w0, a0, f0, base;
  logic [22:0] o;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      if (add_cnt === 1'b0) n_acl++;
      if (px_wr === 1'b1) begin
        n_wr++;
        obs_q.push_back({mem_px_addr, mem_px_data});
        if (frame_done === 1'b1) begin
          n_fd++;
          fd_addr = mem_px_addr;
        end
        chk("write_add_cnt", 32'(add_cnt), 32'd0);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_write: got addr %0d data 0x%0h, expected no write", mem_px_addr, mem_px_data);
        end else begin
          sb_e = exp_q.pop_front();
          chk("write_addr_data_done", {8'd0, mem_px_addr, mem_px_data, frame_done}, {8'd0, sb_e});
        end
      end else begin
        chk("idle_done_addcnt", {30'd0, frame_done, add_cnt}, 32'd1);
      end
    end
  end

  function automatic logic [7:0] m_rgb332(input logic [7:0] hi, input logic [7:0] lo);
    int r5, g6, b5;
    r5 = int'(hi) >> 3;
    g6 = ((int'(hi) & 7) << 3) | (int'(lo) >> 5);
    b5 = int'(lo) & 31;
    return 8'(((r5 >> 2) << 5) | ((g6 >> 3) << 2) | (b5 >> 3));
  endfunction

  function automatic logic [22:0] obs_at(input int idx);
    if (idx < obs_q.size()) return obs_q[idx];
    return '1;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic fill_line(input int n, input int seed);
    for (int i = 0; i < n; i++) line_buf[i] = 8'(seed * 29 + i * 53 + i / 7);
  endtask

  // Model: a line of n bytes carries n/2 pixels; only the first H pixels of the first V lines land.
  task automatic model_line(input int n);
    for (int p = 0; p < n / 2; p++) begin
      if (m_cap && (m_col < H) && (m_line < V)) begin
        exp_q.push_back({15'(m_addr), m_rgb332(line_buf[2*p], line_buf[2*p+1]), (m_addr == NPIX - 1)});
        if (m_addr == NPIX - 1) begin
          m_cap  = 1'b0;
          m_idle = !inicio;
        end
        m_addr++;
      end
      m_col++;
    end
    if (n > 0) m_line++;
    m_col = 0;
  endtask

  task automatic drive_line(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      href    = 1'b1;
      px_data = line_buf[i];
      tick();
    end
    href    = 1'b0;
    px_data = 8'd0;
    repeat (gap) tick();
  endtask

  task automatic send_line(input int n, input int gap);
    model_line(n);
    drive_line(n, gap);
  endtask

  task automatic sof();
    if (m_cap) begin
      m_cap  = 1'b0;
      m_idle = 1'b0;
    end
    vsync = 1'b1;
    repeat (3) tick();
    vsync = 1'b0;
    repeat (2) tick();
    if (!m_idle || inicio) begin
      m_idle = 1'b0;
      m_cap  = 1'b1;
      m_addr = 0;
      m_col  = 0;
      m_line = 0;
    end
  endtask

  initial begin
    repeat (3) tick();
    chk_en = 1'b1;
    chk("rst_addr", 32'(mem_px_addr), 32'd0);
    chk("rst_data", 32'(mem_px_data), 32'd0);
    chk("rst_px_wr", 32'(px_wr), 32'd0);
    chk("rst_add_cnt", 32'(add_cnt), 32'd1);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b0;
    tick();

    // inicio low: bus activity is ignored
    sof();
    fill_line(40, 1);
    send_line(40, 2);
    tick();
    chk("idle_no_writes", 32'(n_wr), 32'd0);
    chk("idle_state", 32'(dbg_state), 32'(ST_IDLE));

    // colour packing, oversized line, odd-byte line
    inicio = 1'b1;
    tick();
    sof();
    base = obs_q.size();
    line_buf[0] = 8'hF8; line_buf[1] = 8'h1F; line_buf[2] = 8'h07; line_buf[3] = 8'hE0;
    send_line(4, 2);
    tick();
    o = obs_at(base);
    chk("rgb_f81f", 32'(o[7:0]), 32'h0E3);
    chk("rgb_addr0", 32'(o[22:8]), 32'd0);
    o = obs_at(base + 1);
    chk("rgb_07e0", 32'(o[7:0]), 32'h01C);
    chk("rgb_addr1", 32'(o[22:8]), 32'd1);
    w0 = n_wr;
    fill_line(322, 2);
    send_line(322, 2);
    tick();
    chk("wide_line_writes", 32'(n_wr - w0), 32'd160);
    w0 = n_wr;
    fill_line(3, 3);
    send_line(3, 2);
    tick();
    chk("odd_line_writes", 32'(n_wr - w0), 32'd1);
    base = obs_q.size();
    fill_line(10, 4);
    send_line(10, 2);
    tick();
    o = obs_at(base);
    chk("next_line_addr", 32'(o[22:8]), 32'd163);

    // short frame: vsync rises after 500 pixels
    sof();
    w0 = n_wr;
    f0 = n_fd;
    for (int l = 0; l < 3; l++) begin
      fill_line(320, 10 + l);
      send_line(320, 1);
    end
    fill_line(40, 20);
    model_line(40);
    for (int i = 0; i < 40; i++) begin
      href    = 1'b1;
      px_data = line_buf[i];
      tick();
    end
    vsync   = 1'b1;
    px_data = 8'h55;
    tick();
    m_cap  = 1'b0;
    m_idle = 1'b0;
    href   = 1'b0;
    repeat (3) tick();
    chk("abort_writes", 32'(n_wr - w0), 32'd500);
    chk("abort_no_done", 32'(n_fd - f0), 32'd0);
    chk("abort_state", 32'(dbg_state), 32'(ST_WAIT_SOF));
    sof();
    base = obs_q.size();
    fill_line(10, 21);
    send_line(10, 2);
    tick();
    o = obs_at(base);
    chk("restart_addr0", 32'(o[22:8]), 32'd0);

    // reset while in BYTE_LO of pixel 1000
    sof();
    w0 = n_wr;
    for (int l = 0; l < 6; l++) begin
      fill_line(320, 30 + l);
      send_line(320, 1);
    end
    fill_line(82, 40);
    model_line(80);
    for (int i = 0; i < 81; i++) begin
      href    = 1'b1;
      px_data = line_buf[i];
      tick();
    end
    rst     = 1'b1;
    px_data = line_buf[81];
    tick();
    chk("mid_rst_px_wr", 32'(px_wr), 32'd0);
    chk("mid_rst_add_cnt", 32'(add_cnt), 32'd1);
    chk("mid_rst_addr", 32'(mem_px_addr), 32'd0);
    chk("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst    = 1'b0;
    href   = 1'b0;
    m_idle = 1'b1;
    m_cap  = 1'b0;
    tick();
    chk("mid_rst_writes", 32'(n_wr - w0), 32'd1000);
    w0 = n_wr;
    fill_line(40, 41);
    send_line(40, 2);
    tick();
    chk("post_rst_no_writes", 32'(n_wr - w0), 32'd0);
    chk("post_rst_state", 32'(dbg_state), 32'(ST_WAIT_SOF));

    // full frame with inicio held high
    sof();
    w0 = n_wr;
    a0 = n_acl;
    f0 = n_fd;
    base = obs_q.size();
    for (int l = 0; l < V; l++) begin
      fill_line(2 * H, 100 + l);
      send_line(2 * H, 1);
    end
    repeat (2) tick();
    chk("frame1_writes", 32'(n_wr - w0), 32'd19200);
    chk("frame1_add_cnt_lows", 32'(n_acl - a0), 32'd19200);
    chk("frame1_done_pulses", 32'(n_fd - f0), 32'd1);
    chk("frame1_done_addr", 32'(fd_addr), 32'd19199);
    o = obs_at(base);
    chk("frame1_first_addr", 32'(o[22:8]), 32'd0);
    chk("frame1_state", 32'(dbg_state), 32'(ST_WAIT_SOF));
    chk("frame1_queue_empty", 32'(exp_q.size()), 32'd0);

    // full frame with inicio dropped halfway
    sof();
    w0 = n_wr;
    f0 = n_fd;
    for (int l = 0; l < V; l++) begin
      if (l == 60) inicio = 1'b0;
      fill_line(2 * H, 7 * l + 3);
      send_line(2 * H, 1);
    end
    repeat (2) tick();
    chk("frame2_writes", 32'(n_wr - w0), 32'd19200);
    chk("frame2_done_pulses", 32'(n_fd - f0), 32'd1);
    chk("frame2_state", 32'(dbg_state), 32'(ST_IDLE));
    w0 = n_wr;
    sof();
    fill_line(40, 9);
    send_line(40, 2);
    tick();
    chk("frame2_idle_no_writes", 32'(n_wr - w0), 32'd0);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout, expected end of stimulus");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule
